// File: rtl/pkt_tx.sv
// Packet transmitter: buffers payload bytes in a small FIFO and frames them as
// header / payload / parity packets for a downstream router that can stall.
module pkt_tx #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       fifo_full,
  output logic       ovf,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_dest,
  input  logic [3:0] cmd_len,
  input  logic       cmd_bad_par,
  input  logic       busy,
  output logic       pkt_valid,
  output logic [7:0] data_out,
  output logic [7:0] pkt_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    PARITY,
    GAP
  } state_t;

  logic [7:0]    mem [FIFO_DEPTH];

  state_t        state_q,     state_d;
  logic [AW-1:0] wr_ptr_q,    wr_ptr_d;
  logic [AW-1:0] rd_ptr_q,    rd_ptr_d;
  logic [CW-1:0] count_q,     count_d;
  logic          ovf_q,       ovf_d;
  logic [1:0]    dest_q,      dest_d;
  logic [3:0]    len_q,       len_d;
  logic          bad_q,       bad_d;
  logic [3:0]    rem_q,       rem_d;
  logic [7:0]    parity_q,    parity_d;
  logic          pkt_valid_q, pkt_valid_d;
  logic [7:0]    data_out_q,  data_out_d;
  logic [7:0]    pkt_cnt_q,   pkt_cnt_d;

  logic          full;
  logic          push;
  logic          pop;
  logic          xfer;
  logic [AW-1:0] rd_next;
  logic [7:0]    header;
  logic [7:0]    head_byte;
  logic [7:0]    next_byte;
  logic [7:0]    par_mask;

  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign push      = wr_en & ~full;
  assign xfer      = pkt_valid_q & ~busy;
  assign pop       = xfer & (state_q == PAYLOAD);
  assign rd_next   = rd_ptr_q + AW'(1);
  assign header    = {2'b00, len_q, dest_q};
  assign head_byte = mem[rd_ptr_q];
  assign next_byte = mem[rd_next];
  assign par_mask  = {8{bad_q}};

  assign cmd_ready = (state_q == IDLE) && (count_q >= CW'(cmd_len));
  assign fifo_full = full;
  assign ovf       = ovf_q;
  assign pkt_valid = pkt_valid_q;
  assign data_out  = data_out_q;
  assign pkt_cnt   = pkt_cnt_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    ovf_d       = ovf_q | (wr_en & full);
    dest_d      = dest_q;
    len_d       = len_q;
    bad_d       = bad_q;
    rem_d       = rem_q;
    parity_d    = parity_q;
    pkt_valid_d = pkt_valid_q;
    data_out_d  = data_out_q;
    pkt_cnt_d   = pkt_cnt_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_next;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Every byte-producing state only advances on a transfer, so busy freezes
    // state, data_out and pkt_valid together.
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_d     = HEADER;
          dest_d      = cmd_dest;
          len_d       = cmd_len;
          bad_d       = cmd_bad_par;
          rem_d       = cmd_len;
          parity_d    = 8'h00;
          pkt_valid_d = 1'b1;
          data_out_d  = {2'b00, cmd_len, cmd_dest};
        end
      end
      HEADER: begin
        if (xfer) begin
          parity_d = header;
          if (len_q != 4'd0) begin
            state_d    = PAYLOAD;
            data_out_d = head_byte;
          end else begin
            state_d    = PARITY;
            data_out_d = header ^ par_mask;
          end
        end
      end
      PAYLOAD: begin
        if (xfer) begin
          parity_d = parity_q ^ data_out_q;
          rem_d    = rem_q - 4'd1;
          if (rem_q == 4'd1) begin
            state_d    = PARITY;
            data_out_d = parity_q ^ data_out_q ^ par_mask;
          end else begin
            data_out_d = next_byte;
          end
        end
      end
      PARITY: begin
        if (xfer) begin
          state_d     = GAP;
          pkt_valid_d = 1'b0;
          data_out_d  = 8'h00;
          pkt_cnt_d   = pkt_cnt_q + 8'd1;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        pkt_valid_d = 1'b0;
        data_out_d  = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      dest_q      <= 2'b00;
      len_q       <= 4'd0;
      bad_q       <= 1'b0;
      rem_q       <= 4'd0;
      parity_q    <= 8'h00;
      pkt_valid_q <= 1'b0;
      data_out_q  <= 8'h00;
      pkt_cnt_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      dest_q      <= dest_d;
      len_q       <= len_d;
      bad_q       <= bad_d;
      rem_q       <= rem_d;
      parity_q    <= parity_d;
      pkt_valid_q <= pkt_valid_d;
      data_out_q  <= data_out_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

endmodule

// File: doc/pkt_tx.md
PKT_TX -- requirements
Module: pkt_tx

Interface
REQ-001 The module SHALL have parameter FIFO_DEPTH, default 16, giving the payload buffer depth in bytes (power of 2, at least 16).
REQ-002 The module SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  push payload byte.
- wr_data  in  8  payload byte.
- fifo_full  out  1  payload buffer holds FIFO_DEPTH bytes.
- ovf  out  1  sticky: a push was made while the buffer was full.
- cmd_valid  in  1  packet request.
- cmd_ready  out  1  request accepted when cmd_valid and cmd_ready are both high.
- cmd_dest  in  2  destination channel, 0..3.
- cmd_len  in  4  payload length, 0..15.
- cmd_bad_par  in  1  invert the parity byte (error injection).
- busy  in  1  router downstream cannot take a byte this cycle.
- pkt_valid  out  1  packet in progress, drives the router packet_valid.
- data_out  out  8  byte to the router.
- pkt_cnt  out  8  count of packets fully sent, wraps 255 -> 0.

Function
REQ-003 The payload buffer SHALL be a FIFO_DEPTH-entry byte FIFO with an occupancy count 0..FIFO_DEPTH.
- Push occurs when wr_en=1 and the buffer is not full.
- Pop occurs on each accepted PAYLOAD byte.
REQ-004 Fullness SHALL be evaluated before any same-cycle pop.
- wr_en=1 while full: byte dropped, ovf set to 1, and it stays 1 until rst.
REQ-005 The FSM SHALL have the states IDLE, HEADER, PAYLOAD, PARITY and GAP.
REQ-006 cmd_ready SHALL be combinational: 1 only when state is IDLE and occupancy >= cmd_len.
REQ-007 On acceptance, the module SHALL latch dest, len and bad_par, move to HEADER, and clear the running parity.
REQ-008 Header byte format SHALL be {2'b00, len[3:0], dest[1:0]}.
- dest=3 is transmitted unchanged.
REQ-009 A byte SHALL be transferred on a rising edge where pkt_valid=1 and busy=0.
- While busy=1, data_out, pkt_valid and state hold unchanged.
REQ-010 pkt_valid SHALL be 1 in HEADER, PAYLOAD and PARITY, and 0 in IDLE and GAP.
REQ-011 data_out SHALL be registered, with these contents:
- HEADER: the header byte.
- PAYLOAD: the FIFO head byte.
- PARITY: running XOR of header and all payload bytes, inverted when bad_par is latched.
- IDLE and GAP: 0x00.
REQ-012 State transitions SHALL be:
- HEADER -> PAYLOAD on transfer if len>0; HEADER -> PARITY if len=0.
- PAYLOAD -> PARITY after the len-th transfer.
- PARITY -> GAP on transfer, with pkt_cnt incremented.
- GAP -> IDLE after exactly 1 cycle.
REQ-013 Latency SHALL be as follows:
- Command accepted at edge N: header visible with pkt_valid=1 from cycle N+1.
- With busy=0 throughout, a len-L packet occupies L+2 consecutive valid cycles, then 1 GAP cycle.
REQ-014 Pushes SHALL continue to be accepted during transmission.
- Simultaneous push and pop with the buffer not full: occupancy unchanged.
REQ-015 The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-016 cmd_valid outside IDLE SHALL be ignored, because cmd_ready=0.

Reset
REQ-017 When rst=1 at a rising edge, the following SHALL be set in that cycle, even mid-packet:
- state IDLE, buffer emptied, occupancy 0.
- pkt_valid=0, data_out=0x00.
- fifo_full=0, ovf=0, pkt_cnt=0.
REQ-018 A packet interrupted by rst SHALL NOT be resumed or counted.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- Basic: push 0xAA,0x55,0xCC; cmd dest=0 len=3; busy=0 -> data_out 0x0C,0xAA,0x55,0xCC,0x3F on consecutive pkt_valid cycles, then pkt_valid=0 for 1 cycle; pkt_cnt=1.
- Zero length: cmd dest=2 len=0 with empty buffer -> cmd_ready=1; bytes 0x02 then 0x02; pkt_cnt increments.
- Stall: as Basic, but busy=1 for 3 cycles while 0x55 is shown -> 0x55 held for 4 cycles; sequence and parity 0x3F unchanged.
- Error injection: as Basic with cmd_bad_par=1 -> parity byte 0xC0.
- Overflow and readiness:
  - 17 pushes into an empty buffer -> fifo_full=1, ovf=1.
  - cmd len=15 then accepted; 15 pops deliver the first 15 bytes in order.
  - With 2 bytes buffered, cmd len=3 -> cmd_ready=0.
- Reset mid-packet: assert rst during PAYLOAD -> next cycle pkt_valid=0, data_out=0x00, occupancy 0, pkt_cnt=0.
